// File: rtl/link_frame_sequencer.sv
// link_frame_sequencer: frame-level controller for the Hamming/interleave/QPSK
// link. It enables the interleaver, serializes the interleaved word into 2-bit
// symbols, re-assembles the demodulated symbols after LAT cycles, hands the
// word to the deinterleaver and reports completion.
//
// Handshake semantics: inter_en and deinter_en are level requests held high
// for the whole wait; the partner answers with a single-cycle *_eno strobe
// that is sampled on the clock edge. sym_valid marks every cycle that carries
// a live symbol on sym_o; there is no back-pressure on the symbol path.
//
// Optional build macro LINK_SEQ_LOOPBACK_CHECK_EN adds the `mismatch` output,
// which compares the received word against the transmitted word in DONE.
// dbg_state exposes the FSM state for checkers.
module link_frame_sequencer #(
    parameter int FRAME_BITS = 28,
    parameter int LAT        = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  inter_en,
    input  logic                  inter_eno,
    input  logic [FRAME_BITS-1:0] inter_data_i,
    output logic [1:0]            sym_o,
    output logic                  sym_valid,
    input  logic [1:0]            sym_i,
    output logic                  deinter_en,
    output logic [FRAME_BITS-1:0] deinter_data_o,
    input  logic                  deinter_eno,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            frame_cnt,
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    output logic                  mismatch,
`endif
    output logic [2:0]            dbg_state
);

    localparam int NSYM = FRAME_BITS / 2;
    localparam int KW   = $clog2(NSYM + 1);
    localparam logic [KW-1:0] SYM_LAST = KW'(NSYM - 1);
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTER = 3'd1,
        S_TX    = 3'd2,
        S_DRAIN = 3'd3,
        S_DEINT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] tx_word_q, tx_word_d;
    logic [FRAME_BITS-1:0] rx_word_q, rx_word_d;
    logic [FRAME_BITS-1:0] deint_word_q, deint_word_d;
    logic [KW-1:0]         k_q, k_d;
    logic [KW-1:0]         j_q, j_d;
    logic [LAT-1:0]        pipe_q, pipe_d;
    logic [7:0]            to_cnt_q, to_cnt_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  capture;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    logic                  mm_q, mm_d;
`endif

    // Next-state, counters, symbol capture and timeout handling.
    always_comb begin
        state_d      = state_q;
        tx_word_d    = tx_word_q;
        rx_word_d    = rx_word_q;
        deint_word_d = deint_word_q;
        k_d          = k_q;
        j_d          = j_q;
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
        mm_d         = mm_q;
`endif
        // Delay line for sym_valid; its tail marks the cycle sym_i belongs to
        // the symbol issued LAT cycles earlier.
        pipe_d    = pipe_q << 1;
        pipe_d[0] = (state_q == S_TX);
        capture   = pipe_q[LAT-1] && ((state_q == S_TX) || (state_q == S_DRAIN));

        if (capture) begin
            rx_word_d[{j_q, 1'b0} +: 2] = sym_i;
            j_d = j_q + KW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_INTER;
                    err_d    = 1'b0;
                    to_cnt_d = 8'd0;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
                    mm_d     = 1'b0;
`endif
                end
            end
            S_INTER: begin
                if (inter_eno) begin
                    tx_word_d = inter_data_i;
                    k_d       = '0;
                    j_d       = '0;
                    state_d   = S_TX;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_TX: begin
                if (k_q == SYM_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                // Leave on the edge of the final capture so deinter_en rises
                // one cycle after the last symbol lands.
                if (capture && (j_q == SYM_LAST)) begin
                    deint_word_d = rx_word_d;
                    to_cnt_d     = 8'd0;
                    state_d      = S_DEINT;
                end
            end
            S_DEINT: begin
                if (deinter_eno) begin
                    state_d = S_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                cnt_d   = cnt_q + 8'd1;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
                mm_d    = (rx_word_q != tx_word_q);
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tx_word_q    <= '0;
            rx_word_q    <= '0;
            deint_word_q <= '0;
            k_q          <= '0;
            j_q          <= '0;
            pipe_q       <= '0;
            to_cnt_q     <= 8'd0;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
            mm_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_word_q    <= tx_word_d;
            rx_word_q    <= rx_word_d;
            deint_word_q <= deint_word_d;
            k_q          <= k_d;
            j_q          <= j_d;
            pipe_q       <= pipe_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
            mm_q         <= mm_d;
`endif
        end
    end

    // Outputs decode straight from state; sym_o holds the last symbol in DRAIN
    // because k stops at the final index.
    assign inter_en       = (state_q == S_INTER);
    assign sym_valid      = (state_q == S_TX);
    assign sym_o          = tx_word_q[{k_q, 1'b0} +: 2];
    assign deinter_en     = (state_q == S_DEINT);
    assign deinter_data_o = deint_word_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign frame_cnt      = cnt_q;
    assign dbg_state      = state_q;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    assign mismatch       = mm_q;
`endif

endmodule

// File: tb/tb_link_frame_sequencer.sv
// Testbench for link_frame_sequencer: table of frame vectors, hand-written
// timeout/reset/back-to-back sequences, random frames against a word-level
// reference, and a latency sweep on LAT=1 and LAT=15 instances.
module tb_link_frame_sequencer;

  localparam int FB   = 28;
  localparam int NSYM = FB / 2;
  localparam int LAT  = 3;
  localparam int TO   = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, inter_eno, deinter_eno;
  logic [FB-1:0] inter_data_i;
  logic [1:0]    sym_i;
  logic          inter_en, sym_valid, deinter_en, busy, done, err;
  logic [1:0]    sym_o;
  logic [FB-1:0] deinter_data_o;
  logic [7:0]    frame_cnt;
  logic [2:0]    dbg_state;

  // sweep instances share their control inputs
  logic          sw_start, sw_inter_eno, sw_deinter_eno;
  logic [FB-1:0] sw_data;
  logic [1:0]    a_sym_i, b_sym_i, a_sym_o, b_sym_o;
  logic          a_inter_en, a_sym_valid, a_den, a_busy, a_done, a_err;
  logic          b_inter_en, b_sym_valid, b_den, b_busy, b_done, b_err;
  logic [FB-1:0] a_data_o, b_data_o;
  logic [7:0]    a_fcnt, b_fcnt;
  logic [2:0]    a_dbg, b_dbg;
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
  logic          mismatch, a_mm, b_mm;
`endif

  link_frame_sequencer #(.FRAME_BITS(FB), .LAT(LAT), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .start(start), .inter_en(inter_en),
    .inter_eno(inter_eno), .inter_data_i(inter_data_i), .sym_o(sym_o),
    .sym_valid(sym_valid), .sym_i(sym_i), .deinter_en(deinter_en),
    .deinter_data_o(deinter_data_o), .deinter_eno(deinter_eno), .busy(busy),
    .done(done), .err(err), .frame_cnt(frame_cnt),
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    .mismatch(mismatch),
`endif
    .dbg_state(dbg_state)
  );

  link_frame_sequencer #(.FRAME_BITS(FB), .LAT(1), .TIMEOUT(TO)) u_lat1 (
    .clk(clk), .rst(rst), .start(sw_start), .inter_en(a_inter_en),
    .inter_eno(sw_inter_eno), .inter_data_i(sw_data), .sym_o(a_sym_o),
    .sym_valid(a_sym_valid), .sym_i(a_sym_i), .deinter_en(a_den),
    .deinter_data_o(a_data_o), .deinter_eno(sw_deinter_eno), .busy(a_busy),
    .done(a_done), .err(a_err), .frame_cnt(a_fcnt),
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    .mismatch(a_mm),
`endif
    .dbg_state(a_dbg)
  );

  link_frame_sequencer #(.FRAME_BITS(FB), .LAT(15), .TIMEOUT(TO)) u_lat15 (
    .clk(clk), .rst(rst), .start(sw_start), .inter_en(b_inter_en),
    .inter_eno(sw_inter_eno), .inter_data_i(sw_data), .sym_o(b_sym_o),
    .sym_valid(b_sym_valid), .sym_i(b_sym_i), .deinter_en(b_den),
    .deinter_data_o(b_data_o), .deinter_eno(sw_deinter_eno), .busy(b_busy),
    .done(b_done), .err(b_err), .frame_cnt(b_fcnt),
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    .mismatch(b_mm),
`endif
    .dbg_state(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  logic [1:0]    exp_q[$];
  logic [FB-1:0] exp_rx;
  logic [7:0]    exp_cnt;
  bit            sb_en;
  int            cyc_n, last_sv_cyc, done_cnt, last_done_cyc, done_gap;
  int            sv_in_frame;
  logic [1:0]    first_sym, last_sym;
  bit            prev_den;

  // channel models: loopback delay lines with optional forced symbol
  logic [1:0]    h0[$], ha[$], hb[$];
  int            tx_idx, fault_idx;

  int            a_last_sv, b_last_sv, a_rise, b_rise, a_done_cnt, b_done_cnt;
  bit            a_prev, b_prev;
  logic [FB-1:0] a_word, b_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // One clock: sample after the edge, run monitors, then advance channels.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (sym_valid) begin
      if (sv_in_frame == 0) first_sym = sym_o;
      last_sym = sym_o;
      sv_in_frame++;
      last_sv_cyc = cyc_n;
      if (sb_en) begin
        if (exp_q.size() == 0) fail_now("sym_extra");
        else chk("sym_o", 32'(sym_o), 32'(exp_q.pop_front()));
      end
    end
    if (deinter_en && !prev_den) begin
      chk("den_latency", cyc_n - last_sv_cyc, LAT + 1);
      chk("deinter_data", 32'(deinter_data_o), 32'(exp_rx));
    end
    prev_den = deinter_en;
    if (done) begin
      if (last_done_cyc > 0) done_gap = cyc_n - last_done_cyc;
      last_done_cyc = cyc_n;
      done_cnt++;
    end
    h0.push_back((sym_valid && tx_idx == fault_idx) ? 2'b00 : sym_o);
    tx_idx = sym_valid ? tx_idx + 1 : 0;
    if (h0.size() > LAT) sym_i = h0.pop_front();

    if (a_sym_valid) a_last_sv = cyc_n;
    if (a_den && !a_prev) begin a_rise = cyc_n; a_word = a_data_o; end
    a_prev = a_den;
    if (a_done) a_done_cnt++;
    ha.push_back(a_sym_o);
    if (ha.size() > 1) a_sym_i = ha.pop_front();

    if (b_sym_valid) b_last_sv = cyc_n;
    if (b_den && !b_prev) begin b_rise = cyc_n; b_word = b_data_o; end
    b_prev = b_den;
    if (b_done) b_done_cnt++;
    hb.push_back(b_sym_o);
    if (hb.size() > 15) b_sym_i = hb.pop_front();
  endtask

  task automatic check_reset_outputs();
    chk("rst_inter_en", 32'(inter_en), 0);
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_deinter_en", 32'(deinter_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sym_o", 32'(sym_o), 0);
    chk("rst_deinter_data", 32'(deinter_data_o), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    chk("rst_mismatch", 32'(mismatch), 0);
`endif
  endtask

  // Queue the symbols a word must produce: chunk k is bits [2k+1:2k].
  task automatic load_frame(input logic [FB-1:0] word, input logic [FB-1:0] rx);
    inter_data_i = word;
    exp_rx = rx;
    sv_in_frame = 0;
    for (int i = 0; i < NSYM; i++) exp_q.push_back(word[2*i +: 2]);
  endtask

  task automatic run_frame(input logic [FB-1:0] word, input int eno_dly, input int den_dly,
                           input int fidx, input bit pulse_tx, input logic [1:0] x_first,
                           input logic [1:0] x_last, input logic [FB-1:0] x_rx, input bit x_mm);
    int n;
    int d0;
    d0 = done_cnt;
    load_frame(word, x_rx);
    fault_idx = fidx;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_inter_en", 32'(inter_en), 1);
    chk("start_err_clear", 32'(err), 0);
    repeat (eno_dly) cyc();
    inter_eno = 1'b1;
    cyc();
    inter_eno = 1'b0;
    chk("eno_inter_en_low", 32'(inter_en), 0);
    chk("eno_first_valid", 32'(sym_valid), 1);
    if (pulse_tx) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
    end
    n = 0;
    while (!deinter_en && n < 100) begin cyc(); n++; end
    if (!deinter_en) fail_now("deinter_en_wait");
    chk("first_sym", 32'(first_sym), 32'(x_first));
    chk("last_sym", 32'(last_sym), 32'(x_last));
    chk("sym_count", sv_in_frame, NSYM);
    chk("sym_queue_left", exp_q.size(), 0);
    repeat (den_dly) cyc();
    chk("deint_hold", 32'(deinter_en), 1);
    chk("done_early", 32'(done), 0);
    deinter_eno = 1'b1;
    cyc();
    deinter_eno = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    cyc();
    exp_cnt = exp_cnt + 8'd1;
    chk("done_low", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("done_count", done_cnt, d0 + 1);
    chk("deinter_hold", 32'(deinter_data_o), 32'(x_rx));
`ifdef LINK_SEQ_LOOPBACK_CHECK_EN
    chk("mismatch", 32'(mismatch), 32'(x_mm));
`endif
    fault_idx = -1;
  endtask

  typedef struct {
    logic [FB-1:0] word;
    int            eno_dly;
    int            den_dly;
    int            fidx;
    bit            pulse_tx;
    logic [1:0]    x_first;
    logic [1:0]    x_last;
    logic [FB-1:0] x_rx;
    bit            x_mm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    logic [FB-1:0] w, rx;
    int fi;

    vecs[0] = '{28'hA5C396F, 2, 0, -1, 1'b0, 2'b11, 2'b10, 28'hA5C396F, 1'b0};
    vecs[1] = '{28'hA5C396F, 1, 2,  4, 1'b0, 2'b11, 2'b10, 28'hA5C386F, 1'b1};
    vecs[2] = '{28'h0000001, 0, 1, -1, 1'b1, 2'b01, 2'b00, 28'h0000001, 1'b0};
    vecs[3] = '{28'hFFFFFFF, 3, 0, 13, 1'b0, 2'b11, 2'b11, 28'h3FFFFFF, 1'b1};
    vecs[4] = '{28'h8000002, 0, 3,  0, 1'b1, 2'b10, 2'b10, 28'h8000000, 1'b1};
    vecs[5] = '{28'h0000000, 0, 0,  5, 1'b0, 2'b00, 2'b00, 28'h0000000, 1'b0};

    rst = 1'b0; start = 1'b0; inter_eno = 1'b0; deinter_eno = 1'b0;
    inter_data_i = '0; sym_i = 2'b00;
    sw_start = 1'b0; sw_inter_eno = 1'b0; sw_deinter_eno = 1'b0; sw_data = '0;
    a_sym_i = 2'b00; b_sym_i = 2'b00;
    sb_en = 1'b1; fault_idx = -1; tx_idx = 0; exp_cnt = 8'd0; exp_rx = '0;
    cyc_n = 0; last_sv_cyc = 0; done_cnt = 0; last_done_cyc = 0; done_gap = 0;
    sv_in_frame = 0; prev_den = 1'b0; first_sym = 2'b00; last_sym = 2'b00;
    a_last_sv = 0; b_last_sv = 0; a_rise = 0; b_rise = 0;
    a_done_cnt = 0; b_done_cnt = 0; a_prev = 1'b0; b_prev = 1'b0;
    a_word = '0; b_word = '0;

    repeat (3) cyc();
    check_reset_outputs();
    rst = 1'b1;
    cyc();

    // table-driven frames
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].word, vecs[i].eno_dly, vecs[i].den_dly, vecs[i].fidx,
                vecs[i].pulse_tx, vecs[i].x_first, vecs[i].x_last, vecs[i].x_rx, vecs[i].x_mm);

    // interleaver never answers
    d0 = done_cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (inter_en && n < 300) begin n++; cyc(); end
    chk("inter_timeout_len", n, TO);
    chk("inter_timeout_err", 32'(err), 1);
    chk("inter_timeout_idle", 32'(busy), 0);
    chk("inter_timeout_nodone", done_cnt, d0);
    chk("inter_timeout_cnt", 32'(frame_cnt), 32'(exp_cnt));
    // next start clears err (checked inside run_frame)
    run_frame(vecs[0].word, 0, 0, -1, 1'b0, vecs[0].x_first, vecs[0].x_last, vecs[0].x_rx, 1'b0);

    // deinterleaver never answers
    d0 = done_cnt;
    load_frame(28'h1357ACE, 28'h1357ACE);
    start = 1'b1;
    cyc();
    start = 1'b0;
    inter_eno = 1'b1;
    cyc();
    inter_eno = 1'b0;
    n = 0;
    while (!deinter_en && n < 100) begin cyc(); n++; end
    if (!deinter_en) fail_now("deint_to_wait");
    n = 0;
    while (deinter_en && n < 300) begin n++; cyc(); end
    chk("deint_timeout_len", n, TO);
    chk("deint_timeout_err", 32'(err), 1);
    chk("deint_timeout_idle", 32'(busy), 0);
    chk("deint_timeout_nodone", done_cnt, d0);
    chk("deint_timeout_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("deint_timeout_hold", 32'(deinter_data_o), 32'h1357ACE);

    // reset at symbol 7
    load_frame(28'h2468BDF, 28'h2468BDF);
    start = 1'b1;
    cyc();
    start = 1'b0;
    inter_eno = 1'b1;
    cyc();
    inter_eno = 1'b0;
    n = 0;
    while (sv_in_frame < 7 && n < 50) begin cyc(); n++; end
    if (sv_in_frame < 7) fail_now("sym7_wait");
    rst = 1'b0;
    cyc();
    check_reset_outputs();
    rst = 1'b1;
    exp_q.delete();
    h0.delete();
    exp_cnt = 8'd0;
    cyc();
    run_frame(vecs[0].word, 2, 0, -1, 1'b0, vecs[0].x_first, vecs[0].x_last, vecs[0].x_rx, 1'b0);

    // random frames against the word-level model
    for (int r = 0; r < 12; r++) begin
      w = FB'($urandom);
      fi = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NSYM - 1));
      rx = w;
      if (fi >= 0) rx[2*fi +: 2] = 2'b00;
      run_frame(w, $urandom_range(0, 4), $urandom_range(0, 4), fi, 1'($urandom_range(0, 1)),
                w[1:0], w[FB-1:FB-2], rx, (rx != w));
    end

    // start held high: 256 back-to-back frames, counter wraps through 255->0
    sb_en = 1'b0;
    inter_data_i = 28'h0F1E2D3;
    exp_rx = 28'h0F1E2D3;
    d0 = done_cnt;
    start = 1'b1; inter_eno = 1'b1; deinter_eno = 1'b1;
    n = 0;
    while (done_cnt < d0 + 256 && n < 7000) begin cyc(); n++; end
    start = 1'b0; inter_eno = 1'b0; deinter_eno = 1'b0;
    if (done_cnt < d0 + 256) fail_now("b2b_wait");
    chk("b2b_period", done_gap, 2 + NSYM + LAT + 2);
    cyc();
    exp_cnt = exp_cnt + 8'd0;
    chk("b2b_wrap_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("b2b_idle", 32'(busy), 0);
    cyc();
    chk("b2b_stopped", 32'(busy), 0);
    sb_en = 1'b1;

    // latency sweep: LAT=1 and LAT=15 loopback
    sw_data = FB'($urandom);
    sw_deinter_eno = 1'b1;
    sw_start = 1'b1;
    cyc();
    sw_start = 1'b0;
    chk("sw_a_inter_en", 32'(a_inter_en), 1);
    chk("sw_b_inter_en", 32'(b_inter_en), 1);
    cyc();
    sw_inter_eno = 1'b1;
    cyc();
    sw_inter_eno = 1'b0;
    n = 0;
    while ((a_done_cnt < 1 || b_done_cnt < 1) && n < 80) begin cyc(); n++; end
    if (a_done_cnt < 1 || b_done_cnt < 1) fail_now("sweep_wait");
    sw_deinter_eno = 1'b0;
    chk("lat1_den_latency", a_rise - a_last_sv, 2);
    chk("lat15_den_latency", b_rise - b_last_sv, 16);
    chk("lat1_word", 32'(a_word), 32'(sw_data));
    chk("lat15_word", 32'(b_word), 32'(sw_data));
    repeat (2) cyc();
    chk("lat1_done_count", a_done_cnt, 1);
    chk("lat15_done_count", b_done_cnt, 1);
    chk("lat1_frame_cnt", 32'(a_fcnt), 1);
    chk("lat15_frame_cnt", 32'(b_fcnt), 1);
    chk("lat1_idle", 32'(a_busy), 0);
    chk("lat15_idle", 32'(b_busy), 0);
    chk("lat1_err", 32'(a_err), 0);
    chk("lat15_err", 32'(b_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
